// File: rtl/reduce_sum_scheduler_if.sv
// Bundled requester, engine and result signals of reduce_sum_scheduler.
// The slave modport is the scheduler's view; master is the surrounding fabric/engine.
interface reduce_sum_scheduler_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        grant;
   logic [DATA_W-1:0]       eng_in_data;
   logic                    eng_in_valid;
   logic [DATA_W-1:0]       eng_out_data;
   logic                    eng_out_valid;
   logic [DATA_W-1:0]       res_data;
   logic                    res_valid;
   logic [ID_W-1:0]         res_id;
   logic                    res_timeout;
   logic                    busy;
   logic                    spurious_err;

   modport slave (
      input  req_valid, req_data, eng_out_data, eng_out_valid,
      output req_ready, grant, eng_in_data, eng_in_valid,
             res_data, res_valid, res_id, res_timeout, busy, spurious_err
   );

   modport master (
      output req_valid, req_data, eng_out_data, eng_out_valid,
      input  req_ready, grant, eng_in_data, eng_in_valid,
             res_data, res_valid, res_id, res_timeout, busy, spurious_err
   );
endinterface

// File: rtl/reduce_sum_scheduler.sv
// Round-robin owner of a shared reduce_sum engine: streams one FRAME_LEN frame per grant,
// then returns the engine result tagged with the requester ID, or a timeout.
module reduce_sum_scheduler #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned FRAME_LEN   = 512,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RES_TIMEOUT = 64
) (
   input logic                  clk,
   input logic                  rst,
   reduce_sum_scheduler_if.slave bus
);
   localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned TMR_W = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_e;

   state_e              state_q;
   logic [N_REQ-1:0]    grant_q;
   logic [ID_W-1:0]     gidx_q;
   logic [ID_W-1:0]     last_q;
   logic [CNT_W-1:0]    word_cnt_q;
   logic [TMR_W-1:0]    timer_q;
   logic [DATA_W-1:0]   eng_in_data_q;
   logic                eng_in_valid_q;
   logic [DATA_W-1:0]   res_data_q;
   logic                res_valid_q;
   logic [ID_W-1:0]     res_id_q;
   logic                res_timeout_q;
   logic                spurious_q;

   logic                pick_ok;
   logic [ID_W-1:0]     pick_idx;
   logic [ID_W-1:0]     cand;
   logic [DATA_W-1:0]   sel_data;
   logic                xfer;

   // Scan from the requester after the last owner, wrapping, and take the first one requesting.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((32'(last_q) + k) % N_REQ);
         if (!pick_ok && bus.req_valid[cand]) begin
            pick_ok  = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gidx_q == ID_W'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   assign xfer = (state_q == STREAM) && |(bus.req_valid & grant_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         grant_q        <= '0;
         gidx_q         <= '0;
         last_q         <= ID_W'(N_REQ - 1);
         word_cnt_q     <= '0;
         timer_q        <= '0;
         eng_in_data_q  <= '0;
         eng_in_valid_q <= 1'b0;
         res_data_q     <= '0;
         res_valid_q    <= 1'b0;
         res_id_q       <= '0;
         res_timeout_q  <= 1'b0;
         spurious_q     <= 1'b0;
      end else begin
         eng_in_valid_q <= 1'b0;
         res_valid_q    <= 1'b0;
         res_timeout_q  <= 1'b0;
         if (bus.eng_out_valid && state_q != WAIT) spurious_q <= 1'b1;

         unique case (state_q)
            IDLE: begin
               if (pick_ok) begin
                  grant_q    <= N_REQ'(1) << pick_idx;
                  gidx_q     <= pick_idx;
                  word_cnt_q <= '0;
                  timer_q    <= '0;
                  state_q    <= STREAM;
               end
            end
            STREAM: begin
               if (xfer) begin
                  eng_in_data_q  <= sel_data;
                  eng_in_valid_q <= 1'b1;
                  if (word_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                     word_cnt_q <= '0;
                     timer_q    <= '0;
                     state_q    <= WAIT;
                  end else begin
                     word_cnt_q <= word_cnt_q + CNT_W'(1);
                  end
               end
            end
            WAIT: begin
               // A result arriving on the timeout cycle takes precedence.
               if (bus.eng_out_valid) begin
                  res_data_q  <= bus.eng_out_data;
                  res_id_q    <= gidx_q;
                  res_valid_q <= 1'b1;
                  last_q      <= gidx_q;
                  grant_q     <= '0;
                  timer_q     <= '0;
                  state_q     <= IDLE;
               end else if (timer_q == TMR_W'(RES_TIMEOUT - 1)) begin
                  res_data_q    <= '0;
                  res_id_q      <= gidx_q;
                  res_valid_q   <= 1'b1;
                  res_timeout_q <= 1'b1;
                  last_q        <= gidx_q;
                  grant_q       <= '0;
                  timer_q       <= '0;
                  state_q       <= IDLE;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = (state_q == STREAM) ? grant_q : '0;
   assign bus.grant        = grant_q;
   assign bus.eng_in_data  = eng_in_data_q;
   assign bus.eng_in_valid = eng_in_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_id       = res_id_q;
   assign bus.res_timeout  = res_timeout_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.spurious_err = spurious_q;
endmodule

// File: tb/tb_reduce_sum_scheduler.sv
// Bench for reduce_sum_scheduler: behavioural engine stub, event-level reference model
// checked every negedge, and literal grant/result sequences for the directed scenarios.
module tb_reduce_sum_scheduler;
   localparam int N  = 4;
   localparam int FL = 512;
   localparam int DW = 32;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reduce_sum_scheduler_if #(.N_REQ(N), .DATA_W(DW)) bus ();

   reduce_sum_scheduler #(
      .N_REQ(N), .FRAME_LEN(FL), .DATA_W(DW), .RES_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Engine stub: sums FL words, answers 4 cycles later unless muted.
   logic        e_ov = 1'b0;
   logic        spur_force = 1'b0;
   logic [31:0] e_od = '0;
   bit          eng_mute = 1'b0;
   int          e_cnt, e_dly;
   logic [31:0] e_sum, e_done;

   assign bus.eng_out_valid = e_ov | spur_force;
   assign bus.eng_out_data  = e_od;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_cnt = 0; e_sum = '0; e_dly = 0; e_done = '0;
         e_ov <= 1'b0; e_od <= '0;
      end else begin
         e_ov <= 1'b0;
         if (e_dly == 1) begin e_ov <= 1'b1; e_od <= e_done; end
         if (e_dly > 0) e_dly--;
         if (bus.eng_in_valid) begin
            e_sum += bus.eng_in_data;
            e_cnt++;
            if (e_cnt == FL) begin
               e_done = e_sum; e_sum = '0; e_cnt = 0;
               if (!eng_mute) e_dly = 3;
            end
         end
      end
   end

   // Reference model: owner/phase tracked at transaction level, expectations for the next edge.
   int          m_last = N - 1, m_owner = -1, m_cnt = 0, m_wcyc = 0, exp_grant = -1, n_pulses = 0;
   bit          m_wait = 0, exp_in_v = 0, exp_res = 0, exp_to = 0, m_spur = 0;
   logic [31:0] exp_in_d = '0, exp_res_d = '0, m_sum = '0;
   int          grant_log[$];
   int          rid_log[$];
   logic [31:0] rdata_log[$];
   bit          rto_log[$];

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_grant", bus.grant, 0);
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_eng_in_valid", bus.eng_in_valid, 0);
         chk("rst_res_valid", bus.res_valid, 0);
         chk("rst_spurious", bus.spurious_err, 0);
         m_last = N - 1; m_owner = -1; m_cnt = 0; m_wcyc = 0; exp_grant = -1; n_pulses = 0;
         m_wait = 0; exp_in_v = 0; exp_res = 0; exp_to = 0; m_spur = 0; m_sum = '0;
      end else begin
         chk("eng_in_valid", bus.eng_in_valid, exp_in_v);
         if (exp_in_v) chk("eng_in_data", bus.eng_in_data, exp_in_d);
         if (bus.eng_in_valid) n_pulses++;
         chk("res_valid", bus.res_valid, exp_res);
         chk("res_timeout", bus.res_timeout, exp_res & exp_to);
         if (exp_res) begin
            chk("res_data", bus.res_data, exp_res_d);
            chk("res_id", bus.res_id, m_owner);
            chk("frame_pulses", n_pulses, FL);
            rid_log.push_back(int'(bus.res_id));
            rdata_log.push_back(bus.res_data);
            rto_log.push_back(bus.res_timeout);
            m_owner = -1; m_wait = 0;
         end
         if (exp_grant >= 0) begin
            m_owner = exp_grant; m_cnt = 0; m_sum = '0; n_pulses = 0;
            grant_log.push_back(exp_grant);
         end
         chk("grant", bus.grant, (m_owner < 0) ? 0 : (1 << m_owner));
         chk("busy", bus.busy, m_owner >= 0);
         chk("req_ready", bus.req_ready, (m_owner >= 0 && !m_wait) ? (1 << m_owner) : 0);
         chk("spurious_err", bus.spurious_err, m_spur);

         exp_in_v = 0; exp_res = 0; exp_to = 0; exp_grant = -1;
         if (bus.eng_out_valid && !m_wait) m_spur = 1;
         if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               if (exp_grant < 0 && bus.req_valid[(m_last + k) % N]) exp_grant = (m_last + k) % N;
            end
         end else if (!m_wait) begin
            if (bus.req_valid[m_owner]) begin
               exp_in_v = 1;
               exp_in_d = bus.req_data[m_owner*DW +: DW];
               m_sum += exp_in_d;
               m_cnt++;
               if (m_cnt == FL) begin m_wait = 1; m_wcyc = 0; end
            end
         end else begin
            if (bus.eng_out_valid) begin
               exp_res = 1; exp_res_d = bus.eng_out_data;
               chk("engine_sum", bus.eng_out_data, m_sum);
            end else if (m_wcyc == TO - 1) begin
               exp_res = 1; exp_to = 1; exp_res_d = '0;
            end else begin
               m_wcyc++;
            end
            if (exp_res) m_last = m_owner;
         end
      end
   end

   task automatic set_data(input int id, input logic [31:0] v);
      bus.req_data[id*DW +: DW] = v;
   endtask

   task automatic run_until(input int n_res, input int budget,
                            input logic [N-1:0] base, input logic [N-1:0] rnd);
      int seen = 0;
      int cyc = 0;
      bus.req_valid = base;
      while (seen < n_res && cyc < budget) begin
         @(posedge clk); #1; cyc++;
         if (bus.res_valid) seen++;
         if (seen >= n_res) bus.req_valid = '0;
         else bus.req_valid = base | (rnd & N'($urandom));
      end
      bus.req_valid = '0;
      chk("results_within_budget", seen, n_res);
   endtask

   int          exp_g[12]  = '{0, 0, 1, 2, 3, 0, 2, 3, 0, 1, 0, 2};
   int          exp_id[11] = '{0, 0, 1, 2, 3, 0, 2, 3, 0, 0, 2};
   logic [31:0] exp_d[11]  = '{32'h200, 32'h200, 32'h400, 32'h600, 32'h800, 32'h200,
                               32'h200, 32'h0, 32'h400, 32'h600, 32'h800};
   bit          exp_t[11]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, cyc;
      bus.req_valid = '0;
      bus.req_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single requester, words of 1.
      set_data(0, 32'd1);
      run_until(1, 3000, 4'b0001, 4'b0000);

      // Fresh arbitration, all requesting with data id+1.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < N; i++) set_data(i, 32'(i + 1));
      run_until(5, 6000, 4'b1111, 4'b0000);

      // Requester 2 with random stalls.
      set_data(2, 32'd1);
      run_until(1, 5000, 4'b0000, 4'b0100);

      // Silent engine -> timeout, then a normal frame.
      eng_mute = 1'b1;
      set_data(3, 32'd5);
      run_until(1, 3000, 4'b1000, 4'b0000);
      eng_mute = 1'b0;
      set_data(0, 32'd2);
      run_until(1, 3000, 4'b0001, 4'b0000);

      // Reset after 100 transfers of requester 1.
      set_data(1, 32'd1);
      bus.req_valid = 4'b0010;
      cnt = 0; cyc = 0;
      while (cnt < 100 && cyc < 1000) begin
         @(posedge clk); #1; cyc++;
         if (bus.eng_in_valid) cnt++;
      end
      chk("transfers_before_reset", cnt, 100);
      #1 rst = 1'b1;
      #1;
      chk("async_grant", bus.grant, 0);
      chk("async_req_ready", bus.req_ready, 0);
      chk("async_busy", bus.busy, 0);
      chk("async_eng_in_valid", bus.eng_in_valid, 0);
      chk("async_eng_in_data", bus.eng_in_data, 0);
      chk("async_res_data", bus.res_data, 0);
      chk("async_res_id", bus.res_id, 0);
      bus.req_valid = 4'b0011;
      set_data(0, 32'd3);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_until(1, 3000, 4'b0011, 4'b0000);

      // Stray engine result while idle.
      @(posedge clk); #1 spur_force = 1'b1;
      @(posedge clk); #1 spur_force = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("spurious_set", bus.spurious_err, 1);
      set_data(2, 32'd4);
      run_until(1, 3000, 4'b0100, 4'b0000);
      repeat (3) @(posedge clk);
      #1 chk("spurious_sticky", bus.spurious_err, 1);

      chk("grant_count", grant_log.size(), 12);
      chk("result_count", rid_log.size(), 11);
      for (int i = 0; i < 12 && i < grant_log.size(); i++) chk($sformatf("grant_seq[%0d]", i), grant_log[i], exp_g[i]);
      for (int i = 0; i < 11 && i < rid_log.size(); i++) begin
         chk($sformatf("res_id_seq[%0d]", i), rid_log[i], exp_id[i]);
         chk($sformatf("res_data_seq[%0d]", i), rdata_log[i], exp_d[i]);
         chk($sformatf("res_to_seq[%0d]", i), rto_log[i], exp_t[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
